// File: rtl/char_buffer_fill.sv
// char_buffer_fill: sweeps a rectangular region of a character buffer and
// issues one write per cell (clear screen, test pattern, row clear, status
// line, rectangle). Single clock, synchronous active-high reset.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake; ready only while IDLE
//   cmd_op                - 0=CLS 1=SEQ 2=ROW 3=STAT 4=RECT, 5-7 reserved
//   cmd_row/cmd_row2      - logical start/end row
//   cmd_col/cmd_col2      - start/end column
//   cmd_char              - fill character
//   scroll_row            - physical row shown at the top of the screen
//   wr_stall              - buffer did not take the write this cycle
//   wr_en/wr_addr/wr_data - write port, wr_addr = {col, physical row}
//   done                  - one-cycle pulse at command completion
//
// Optional feature: define CHAR_BUFFER_FILL_RECT_EN to enable RECT. Without it
// op 4 is treated as reserved and cmd_row2/cmd_col2 are unused.
module char_buffer_fill #(
  parameter int COLS   = 80,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5,
  parameter int DATA_W = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [ROW_W-1:0]         cmd_row,
  input  logic [ROW_W-1:0]         cmd_row2,
  input  logic [COL_W-1:0]         cmd_col,
  input  logic [COL_W-1:0]         cmd_col2,
  input  logic [DATA_W-1:0]        cmd_char,
  input  logic [ROW_W-1:0]         scroll_row,
  input  logic                     wr_stall,
  output logic                     wr_en,
  output logic [COL_W+ROW_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     done
);

  localparam logic [2:0] OP_CLS  = 3'd0;
  localparam logic [2:0] OP_SEQ  = 3'd1;
  localparam logic [2:0] OP_ROW  = 3'd2;
  localparam logic [2:0] OP_STAT = 3'd3;
`ifdef CHAR_BUFFER_FILL_RECT_EN
  localparam logic [2:0] OP_RECT = 3'd4;
`endif

  // One extra bit so COLS itself is representable when COLS == 2^COL_W.
  localparam logic [COL_W:0]   COLS_X   = (COL_W+1)'(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Region latched at acceptance; the sweep runs from (col_lo, first row)
  // to (col_hi, row_last), wrapping the row at ROW_W bits.
  logic [COL_W-1:0]  col_lo;
  logic [COL_W-1:0]  col_hi;
  logic [ROW_W-1:0]  row_last;
  logic              seq_mode;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;

  // Decode of the incoming command, used only on the accept cycle.
  logic              acc_empty;
  logic              acc_seq;
  logic [COL_W-1:0]  acc_col_lo;
  logic [COL_W-1:0]  acc_col_hi;
  logic [ROW_W-1:0]  acc_row_first;
  logic [ROW_W-1:0]  acc_row_last;

  always_comb begin
    acc_empty     = 1'b1;
    acc_seq       = 1'b0;
    acc_col_lo    = '0;
    acc_col_hi    = LAST_COL;
    acc_row_first = '0;
    acc_row_last  = '1;
    case (cmd_op)
      OP_CLS: begin
        acc_empty = 1'b0;
      end
      OP_SEQ: begin
        acc_empty = 1'b0;
        acc_seq   = 1'b1;
      end
      OP_ROW: begin
        acc_empty     = ({1'b0, cmd_col} >= COLS_X);
        acc_col_lo    = cmd_col;
        acc_row_first = cmd_row + scroll_row;
        acc_row_last  = cmd_row + scroll_row;
      end
      OP_STAT: begin
        // Status line sits just above the top of the scrolled screen.
        acc_empty     = 1'b0;
        acc_row_first = scroll_row - ROW_W'(1);
        acc_row_last  = scroll_row - ROW_W'(1);
      end
`ifdef CHAR_BUFFER_FILL_RECT_EN
      OP_RECT: begin
        acc_empty     = ({1'b0, cmd_col} >= COLS_X) ||
                        ({1'b0, cmd_col2} >= COLS_X) ||
                        (cmd_col2 < cmd_col);
        acc_col_lo    = cmd_col;
        acc_col_hi    = cmd_col2;
        acc_row_first = cmd_row + scroll_row;
        acc_row_last  = cmd_row2 + scroll_row;
      end
`endif
      default: begin
        acc_empty = 1'b1;
      end
    endcase
  end

`ifndef CHAR_BUFFER_FILL_RECT_EN
  logic unused_rect;
  assign unused_rect = ^{cmd_row2, cmd_col2};
`endif

  assign wr_addr = {cur_col, cur_row};

  logic last_cell;
  assign last_cell = (cur_col == col_hi) && (cur_row == row_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      done      <= 1'b0;
      col_lo    <= '0;
      col_hi    <= '0;
      row_last  <= '0;
      seq_mode  <= 1'b0;
      cur_col   <= '0;
      cur_row   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            col_lo    <= acc_col_lo;
            col_hi    <= acc_col_hi;
            row_last  <= acc_row_last;
            seq_mode  <= acc_seq;
            cur_col   <= acc_col_lo;
            cur_row   <= acc_row_first;
            wr_data   <= acc_seq ? '0 : cmd_char;
            cmd_ready <= 1'b0;
            if (acc_empty) begin
              // Nothing to write: complete straight away.
              state <= DONE;
              wr_en <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= FILL;
              wr_en <= 1'b1;
            end
          end
        end
        FILL: begin
          // A stalled cycle holds address, data and cursor untouched.
          if (!wr_stall) begin
            if (last_cell) begin
              state <= DONE;
              wr_en <= 1'b0;
              done  <= 1'b1;
            end else begin
              if (cur_col == col_hi) begin
                cur_col <= col_lo;
                cur_row <= cur_row + ROW_W'(1);
              end else begin
                cur_col <= cur_col + COL_W'(1);
              end
              if (seq_mode) begin
                wr_data <= wr_data + DATA_W'(1);
              end
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          wr_en     <= 1'b0;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_buffer_fill.sv
module tb_char_buffer_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_row;
  logic [4:0]  cmd_row2;
  logic [6:0]  cmd_col;
  logic [6:0]  cmd_col2;
  logic [6:0]  cmd_char;
  logic [4:0]  scroll_row;
  logic        wr_stall;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic        done;

  char_buffer_fill dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_row    (cmd_row),
    .cmd_row2   (cmd_row2),
    .cmd_col    (cmd_col),
    .cmd_col2   (cmd_col2),
    .cmd_char   (cmd_char),
    .scroll_row (scroll_row),
    .wr_stall   (wr_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] waddr[$];
  logic [6:0]  wdata[$];
  int          hold_err;
  int          done_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int addr_of(input int col, input int row);
    return col * 32 + row;
  endfunction

  // Issue one command, collect every counted write, return the number of
  // cycles after the accept edge at which done was seen (0 on timeout).
  task automatic run(input logic [2:0] op, input int row, input int col,
                     input int row2, input int col2, input int ch,
                     input int scr, input bit stall_tog, input int keep_valid,
                     output int dcyc);
    int          n;
    bit          pstall;
    logic [11:0] pa;
    logic [6:0]  pd;
    waddr.delete();
    wdata.delete();
    hold_err   = 0;
    cmd_op     = op;
    cmd_row    = 5'(row);
    cmd_col    = 7'(col);
    cmd_row2   = 5'(row2);
    cmd_col2   = 7'(col2);
    cmd_char   = 7'(ch);
    scroll_row = 5'(scr);
    wr_stall   = 1'b0;
    cmd_valid  = 1'b1;
    tick();
    // Scramble the inputs: the accepted command must not notice.
    scroll_row = 5'(scr + 7);
    cmd_char   = 7'(ch ^ 'h15);
    cmd_row    = 5'(row + 3);
    cmd_col    = 7'(col + 2);
    cmd_op     = 3'd0;
    cmd_valid  = (keep_valid > 0);
    n      = 1;
    dcyc   = 0;
    pstall = 1'b0;
    pa     = '0;
    pd     = '0;
    while (n < 3000) begin
      if (pstall && (wr_addr !== pa || wr_data !== pd || wr_en !== 1'b1))
        hold_err++;
      pstall = wr_en && wr_stall;
      pa     = wr_addr;
      pd     = wr_data;
      if (wr_en && !wr_stall) begin
        waddr.push_back(wr_addr);
        wdata.push_back(wr_data);
      end
      if (done) begin
        dcyc = n;
        break;
      end
      if (n >= keep_valid) cmd_valid = 1'b0;
      if (stall_tog) wr_stall = ~wr_stall;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    wr_stall  = 1'b0;
    chk("done_seen", int'(dcyc != 0), 1);
    chk("ready_low_in_done", int'(cmd_ready), 0);
    chk("wr_en_low_in_done", int'(wr_en), 0);
    tick();
    chk("done_one_pulse", int'(done), 0);
    chk("ready_back", int'(cmd_ready), 1);
  endtask

  initial begin
    int errs;
    bit seen[4096];

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_row   = '0;
    cmd_row2  = '0;
    cmd_col   = '0;
    cmd_col2  = '0;
    cmd_char  = '0;
    scroll_row = '0;
    wr_stall  = 1'b0;
    tick();
    tick();
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    tick();

    // CLS 0x20: full screen, every address once, done 2561 cycles after the
    // accept edge (cycle 2562 counting the accept cycle as cycle 1).
    run(3'd0, 0, 0, 0, 0, 'h20, 9, 1'b0, 0, done_cyc);
    chk("cls_writes", waddr.size(), 2560);
    chk("cls_done_cycle", done_cyc, 2561);
    errs = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    foreach (waddr[i]) begin
      if (seen[waddr[i]] || waddr[i][11:5] >= 7'd80 || wdata[i] != 7'h20) errs++;
      seen[waddr[i]] = 1'b1;
    end
    chk("cls_unique_cover_data", errs, 0);

    // SEQ: incrementing data wrapping at 128.
    run(3'd1, 0, 0, 0, 0, 'h33, 4, 1'b0, 0, done_cyc);
    chk("seq_writes", waddr.size(), 2560);
    if (waddr.size() == 2560) begin
      chk("seq_first_addr", int'(waddr[0]), 0);
      chk("seq_first_data", int'(wdata[0]), 0);
      chk("seq_second_addr", int'(waddr[1]), addr_of(1, 0));
      chk("seq_81st_addr", int'(waddr[80]), addr_of(0, 1));
      chk("seq_128th_data", int'(wdata[127]), 127);
      chk("seq_129th_data", int'(wdata[128]), 0);
      chk("seq_last_addr", int'(waddr[2559]), addr_of(79, 31));
    end

    // ROW 3 at scroll 30 -> physical row 1, cols 70..79.
    run(3'd2, 3, 70, 0, 0, 'h41, 30, 1'b0, 0, done_cyc);
    chk("row_writes", waddr.size(), 10);
    chk("row_done_cycle", done_cyc, 11);
    errs = 0;
    foreach (waddr[i])
      if (int'(waddr[i]) != addr_of(70 + i, 1) || wdata[i] != 7'h41) errs++;
    chk("row_addr_data", errs, 0);

    // STAT at scroll 0 -> row 31; cmd_valid held high during the fill.
    run(3'd3, 0, 0, 0, 0, 'h7F, 0, 1'b0, 5, done_cyc);
    chk("stat_writes", waddr.size(), 80);
    errs = 0;
    foreach (waddr[i])
      if (int'(waddr[i]) != addr_of(i, 31) || wdata[i] != 7'h7F) errs++;
    chk("stat_addr_data", errs, 0);

`ifdef CHAR_BUFFER_FILL_RECT_EN
    // RECT rows 30..1 (wrapping), cols 5..6, stall toggling every cycle.
    run(3'd4, 30, 5, 1, 6, 'h55, 0, 1'b1, 0, done_cyc);
    chk("rect_writes", waddr.size(), 8);
    chk("rect_hold", hold_err, 0);
    chk("rect_done_cycle", done_cyc, 16);
    errs = 0;
    foreach (waddr[i])
      if (int'(waddr[i]) != addr_of(5 + (i % 2), (30 + i / 2) % 32) ||
          wdata[i] != 7'h55) errs++;
    chk("rect_order", errs, 0);
`else
    // Without the RECT feature op 4 behaves as an empty command.
    run(3'd4, 30, 5, 1, 6, 'h55, 0, 1'b0, 0, done_cyc);
    chk("rect_off_writes", waddr.size(), 0);
    chk("rect_off_done_cycle", done_cyc, 1);
`endif

    // ROW with a column past the screen: empty.
    run(3'd2, 3, 85, 0, 0, 'h41, 0, 1'b0, 0, done_cyc);
    chk("row_empty_writes", waddr.size(), 0);
    chk("row_empty_done_cycle", done_cyc, 1);

    // Reserved op.
    run(3'd6, 0, 0, 0, 0, 'h41, 0, 1'b0, 0, done_cyc);
    chk("rsvd_writes", waddr.size(), 0);
    chk("rsvd_done_cycle", done_cyc, 1);

    // Reset in the middle of a CLS: abort without done, no further writes.
    cmd_op    = 3'd0;
    cmd_char  = 7'h20;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_filling", int'(wr_en), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_en || done) errs++;
      tick();
    end
    chk("abort_quiet", errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
